// File: rtl/sync_period_monitor_n.sv
// rtl/sync_period_monitor_n.sv - multi-channel sync period monitor with qualified 1PPS and holdover
module sync_period_monitor_n #(
  parameter int NCH      = 3,
  parameter int W        = 32,
  parameter int FREQ_CLK = 48_000_000,
  parameter int DELTA    = 5000,
  parameter int LOCK_CNT = 3,
  parameter int PPS_W    = 30,
  parameter int RISE     = 1,
  localparam int SW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   sync_in,
  input  logic [SW-1:0]    pps_sel,
  input  logic             clr,
  input  logic             force_pps,
  output logic [NCH*W-1:0] last_o,
  output logic [NCH*W-1:0] min_o,
  output logic [NCH*W-1:0] max_o,
  output logic [NCH-1:0]   valid_o,
  output logic [NCH-1:0]   timeout_o,
  output logic             locked_o,
  output logic             holdover_o,
  output logic             pps_o,
  output logic [W-1:0]     period_pps_o
);

  localparam logic [W-1:0] ONES    = '1;
  localparam logic [W-1:0] SAT_M1  = ONES - W'(1);
  localparam logic [W-1:0] P_HI    = W'(FREQ_CLK + DELTA);
  localparam logic [W-1:0] P_LO    = W'(FREQ_CLK - DELTA);
  localparam logic [W-1:0] GEN_MAX = W'(FREQ_CLK - 1);
  localparam logic [W-1:0] PPS_END = W'(PPS_W);

  // The good-period window must stay strictly below the saturation value,
  // otherwise a stalled counter could never be told apart from a long period.
  if ((64'(FREQ_CLK) + 64'(DELTA) >= (64'd1 << W) - 64'd1) ||
      (NCH < 1) || (NCH > 16) || (LOCK_CNT < 1) || (LOCK_CNT > 15) ||
      (PPS_W < 1) || (PPS_W >= FREQ_CLK)) begin : g_param_error
    $error("sync_period_monitor_n: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_UNLOCK = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  // Per-channel input path and statistics
  logic [NCH-1:0] s1_q, s2_q, hist_q;
  logic [NCH-1:0] edge_ev, armed_q, sat, rec, valid_q, tout_q;
  logic [W-1:0]   cnt_q  [NCH];
  logic [W-1:0]   per    [NCH];
  logic [W-1:0]   last_q [NCH];
  logic [W-1:0]   min_q  [NCH];
  logic [W-1:0]   max_q  [NCH];

  // Lock FSM, selection and generator
  state_t         state_q, state_d;
  logic [3:0]     gcnt_q, gcnt_d;
  logic           hold_q, hold_d;
  logic [SW-1:0]  sel_q, sel_in, eff_sel;
  logic [W-1:0]   sel_cnt, sel_per;
  logic           sel_edge, sel_rec, in_win, good, bad, realign;
  logic [W-1:0]   gen_q, gen_d;
  logic           pps_q;

  assign edge_ev = (RISE != 0) ? (s2_q & ~hist_q) : (hist_q & ~s2_q);

  // Period candidate, saturation and "this edge records a period" per channel
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      sat[k] = (cnt_q[k] == ONES);
      per[k] = cnt_q[k] + W'(1);
      rec[k] = edge_ev[k] & armed_q[k] & ~sat[k] & ~clr;
    end
  end

  // Synchronisers, period counters, arming and statistics for every channel
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      hist_q  <= '0;
      armed_q <= '0;
      valid_q <= '0;
      tout_q  <= '0;
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k]  <= '0;
        last_q[k] <= '0;
        min_q[k]  <= ONES;
        max_q[k]  <= '0;
      end
    end else begin
      s1_q   <= sync_in;
      s2_q   <= s1_q;
      hist_q <= s2_q;
      for (int k = 0; k < NCH; k++) begin
        if (edge_ev[k]) begin
          cnt_q[k] <= '0;
        end else if (!sat[k]) begin
          cnt_q[k] <= cnt_q[k] + W'(1);
        end

        // An edge always (re)arms, even when it coincides with clr.
        if (edge_ev[k]) begin
          armed_q[k] <= 1'b1;
        end else if (clr) begin
          armed_q[k] <= 1'b0;
        end

        if (clr || edge_ev[k]) begin
          tout_q[k] <= 1'b0;
        end else if (cnt_q[k] == SAT_M1) begin
          tout_q[k] <= 1'b1;
        end

        if (clr) begin
          last_q[k]  <= '0;
          min_q[k]   <= ONES;
          max_q[k]   <= '0;
          valid_q[k] <= 1'b0;
        end else if (rec[k]) begin
          last_q[k]  <= per[k];
          valid_q[k] <= 1'b1;
          if (per[k] < min_q[k]) begin
            min_q[k] <= per[k];
          end
          if (per[k] > max_q[k]) begin
            max_q[k] <= per[k];
          end
        end
      end
    end
  end

  // The selection follows pps_sel live while unlocked and is frozen otherwise
  assign sel_in  = (int'(pps_sel) < NCH) ? pps_sel : '0;
  assign eff_sel = (state_q == S_UNLOCK) ? sel_in : sel_q;

  assign sel_cnt  = cnt_q[eff_sel];
  assign sel_per  = per[eff_sel];
  assign sel_edge = edge_ev[eff_sel];
  assign sel_rec  = rec[eff_sel];
  assign in_win   = (sel_per >= P_LO) && (sel_per <= P_HI);
  assign good     = sel_rec & in_win;
  assign bad      = (sel_rec & ~in_win) | (~sel_edge & (sel_cnt > P_HI));

  // Lock FSM next state; realign whenever a good mark lands in (or enters) LOCKED
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    hold_d  = hold_q;
    realign = 1'b0;
    case (state_q)
      S_UNLOCK: begin
        if (good) begin
          gcnt_d = 4'd1;
          if (LOCK_CNT == 1) begin
            state_d = S_LOCKED;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ACQ;
          end
        end
      end
      S_ACQ: begin
        if (bad) begin
          state_d = S_UNLOCK;
        end else if (good) begin
          gcnt_d = gcnt_q + 4'd1;
          if (int'(gcnt_q) + 1 >= LOCK_CNT) begin
            state_d = S_LOCKED;
            hold_d  = 1'b0;
          end
        end
      end
      S_LOCKED: begin
        if (bad) begin
          state_d = S_UNLOCK;
          hold_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_UNLOCK;
      end
    endcase
    realign = good && (state_d == S_LOCKED);
  end

  // Lock FSM state register and latched channel selection
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_UNLOCK;
      gcnt_q  <= '0;
      hold_q  <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      hold_q  <= hold_d;
      sel_q   <= eff_sel;
    end
  end

  // Generator next count: force and realignment restart, otherwise wrap at one second
  always_comb begin
    if (force_pps || realign) begin
      gen_d = '0;
    end else if (gen_q >= GEN_MAX) begin
      gen_d = '0;
    end else begin
      gen_d = gen_q + W'(1);
    end
  end

  // Generator counter and registered pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      gen_q <= '0;
      pps_q <= 1'b0;
    end else begin
      gen_q <= gen_d;
      pps_q <= (gen_d < PPS_END);
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_pack
    assign last_o[k*W +: W] = last_q[k];
    assign min_o[k*W +: W]  = min_q[k];
    assign max_o[k*W +: W]  = max_q[k];
  end

  assign valid_o      = valid_q;
  assign timeout_o    = tout_q;
  assign locked_o     = (state_q == S_LOCKED);
  assign holdover_o   = hold_q;
  assign pps_o        = pps_q;
  assign period_pps_o = last_q[eff_sel];

endmodule

// File: tb/tb_sync_period_monitor_n.sv
// tb/tb_sync_period_monitor_n.sv - self-checking bench for sync_period_monitor_n
module tb_sync_period_monitor_n;
  localparam int NCH = 3, W = 16, FREQ = 1000, DELTA = 10, LOCKN = 3, PPSW = 4;

  logic clk = 1'b0;
  logic rst, clr, force_pps;
  logic [NCH-1:0] sync_in;
  logic [1:0] pps_sel;
  logic [NCH*W-1:0] last_o, min_o, max_o;
  logic [NCH-1:0] valid_o, timeout_o;
  logic locked_o, holdover_o, pps_o;
  logic [W-1:0] period_pps_o;

  int n_chk = 0;
  int n_err = 0;
  bit saw_lock;

  typedef struct {
    int          gap;
    bit          clr_first;
    logic [15:0] e_last;
    logic [15:0] e_min;
    logic [15:0] e_max;
    bit          e_valid;
  } vec_t;
  vec_t tbl [9];

  // reference model state for the random phase
  logic [15:0] m_last [NCH];
  logic [15:0] m_min  [NCH];
  logic [15:0] m_max  [NCH];
  bit          m_valid [NCH];
  bit          m_armed [NCH];
  int          m_lt [NCH];
  logic [NCH*W-1:0] pk_last, pk_min, pk_max;
  logic [NCH-1:0] pk_valid;

  always #5 clk = ~clk;

  sync_period_monitor_n #(
    .NCH(NCH), .W(W), .FREQ_CLK(FREQ), .DELTA(DELTA),
    .LOCK_CNT(LOCKN), .PPS_W(PPSW), .RISE(1)
  ) dut (
    .clk(clk), .rst(rst), .sync_in(sync_in), .pps_sel(pps_sel),
    .clr(clr), .force_pps(force_pps),
    .last_o(last_o), .min_o(min_o), .max_o(max_o),
    .valid_o(valid_o), .timeout_o(timeout_o),
    .locked_o(locked_o), .holdover_o(holdover_o),
    .pps_o(pps_o), .period_pps_o(period_pps_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (locked_o) saw_lock = 1'b1;
  endtask

  task automatic pulse(input int ch, input int gap);
    sync_in[ch] = 1'b1;
    step();
    sync_in[ch] = 1'b0;
    repeat (gap - 1) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; sync_in = '0; clr = 1'b0; force_pps = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_last"}, last_o, 48'h0);
    chk({tag, "_min"}, min_o, 48'hffff_ffff_ffff);
    chk({tag, "_max"}, max_o, 48'h0);
    chk({tag, "_valid"}, valid_o, 3'b000);
    chk({tag, "_timeout"}, timeout_o, 3'b000);
    chk({tag, "_locked"}, locked_o, 1'b0);
    chk({tag, "_holdover"}, holdover_o, 1'b0);
    chk({tag, "_pps"}, pps_o, 1'b0);
    chk({tag, "_period_pps"}, period_pps_o, 16'h0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0] h1, h2, h3, nin, ev;
    bit cl;
    int ph, p;

    tbl[0] = '{100, 1'b0, 16'd0,   16'hffff, 16'd0,   1'b0};
    tbl[1] = '{120, 1'b0, 16'd100, 16'd100,  16'd100, 1'b1};
    tbl[2] = '{100, 1'b0, 16'd120, 16'd100,  16'd120, 1'b1};
    tbl[3] = '{60,  1'b0, 16'd100, 16'd100,  16'd120, 1'b1};
    tbl[4] = '{30,  1'b0, 16'd60,  16'd60,   16'd120, 1'b1};
    tbl[5] = '{40,  1'b1, 16'd0,   16'hffff, 16'd0,   1'b0};
    tbl[6] = '{80,  1'b0, 16'd40,  16'd40,   16'd40,  1'b1};
    tbl[7] = '{10,  1'b0, 16'd80,  16'd40,   16'd80,  1'b1};
    tbl[8] = '{20,  1'b0, 16'd10,  16'd10,   16'd80,  1'b1};

    pps_sel = 2'd0;
    saw_lock = 1'b0;
    do_reset();
    chk_reset("rst");

    // channel 0 statistics from the table
    repeat (4) step();
    for (int r = 0; r < 9; r++) begin
      if (tbl[r].clr_first) begin
        clr = 1'b1; step(); clr = 1'b0;
      end
      pulse(0, tbl[r].gap);
      chk($sformatf("tbl%0d_last", r), last_o[15:0], tbl[r].e_last);
      chk($sformatf("tbl%0d_min", r), min_o[15:0], tbl[r].e_min);
      chk($sformatf("tbl%0d_max", r), max_o[15:0], tbl[r].e_max);
      chk($sformatf("tbl%0d_valid", r), valid_o[0], tbl[r].e_valid);
      chk($sformatf("tbl%0d_period_pps", r), period_pps_o, tbl[r].e_last);
    end

    // lock on channel 2 at a 1000-cycle pitch, then realign on a 1005 period
    do_reset();
    pps_sel = 2'd2;
    repeat (3) pulse(2, 1000);
    sync_in[2] = 1'b1; step(); sync_in[2] = 1'b0; step();
    chk("lock_before_4th", locked_o, 1'b0);
    step();
    chk("lock_after_4th", locked_o, 1'b1);
    chk("lock_pps_rise", pps_o, 1'b1);
    chk("lock_period_pps", period_pps_o, 16'd1000);
    repeat (3) step();
    chk("lock_pps_width_hi", pps_o, 1'b1);
    step();
    chk("lock_pps_width_lo", pps_o, 1'b0);
    repeat (998) step();
    sync_in[2] = 1'b1; step(); sync_in[2] = 1'b0; step(); step();
    chk("realign_pps", pps_o, 1'b1);
    chk("realign_period", period_pps_o, 16'd1005);
    chk("realign_locked", locked_o, 1'b1);
    repeat (4) step();
    chk("realign_pps_end", pps_o, 1'b0);

    // channel 2 stops: loss of lock, holdover keeps the phase
    repeat (995) step();
    chk("hold_pps_999", pps_o, 1'b0);
    step();
    chk("hold_pps_1000", pps_o, 1'b1);
    repeat (11) step();
    chk("hold_locked_1011", locked_o, 1'b1);
    step();
    chk("hold_locked_1012", locked_o, 1'b0);
    chk("hold_holdover", holdover_o, 1'b1);
    repeat (987) step();
    chk("hold_pps_1999", pps_o, 1'b0);
    step();
    chk("hold_pps_2000", pps_o, 1'b1);

    // a short period during acquisition drops back to UNLOCK
    do_reset();
    pps_sel = 2'd2;
    saw_lock = 1'b0;
    pulse(2, 1000);
    pulse(2, 1000);
    pulse(2, 985);
    repeat (3) pulse(2, 1005);
    chk("acq_never_locked", saw_lock, 1'b0);
    sync_in[2] = 1'b1; step(); sync_in[2] = 1'b0; step(); step();
    chk("acq_relock", locked_o, 1'b1);
    chk("acq_relock_holdover", holdover_o, 1'b0);

    // force_pps in UNLOCK, then reset in the middle of a pulse
    do_reset();
    repeat (10) step();
    force_pps = 1'b1; step(); force_pps = 1'b0;
    chk("force_pps_rise", pps_o, 1'b1);
    repeat (3) step();
    chk("force_pps_hi3", pps_o, 1'b1);
    step();
    chk("force_pps_lo4", pps_o, 1'b0);
    repeat (995) step();
    chk("force_pps_999", pps_o, 1'b0);
    step();
    chk("force_pps_1000", pps_o, 1'b1);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    chk_reset("midrst");

    // random edges and clears against the event-level model
    do_reset();
    pps_sel = 2'd0;
    repeat (4) step();
    for (int k = 0; k < NCH; k++) begin
      m_last[k] = '0; m_min[k] = 16'hffff; m_max[k] = '0;
      m_valid[k] = 1'b0; m_armed[k] = 1'b0; m_lt[k] = 0;
    end
    h1 = '0; h2 = '0; h3 = '0; ph = 0;
    for (int i = 0; i < 2500; i++) begin
      nin = sync_in;
      for (int k = 0; k < NCH; k++) if ($urandom_range(5) == 0) nin[k] = ~nin[k];
      cl = ($urandom_range(63) == 0);
      sync_in = nin; clr = cl; force_pps = (i == 0);
      ev = h2 & ~h3;
      for (int k = 0; k < NCH; k++) begin
        if (cl) begin
          m_last[k] = '0; m_min[k] = 16'hffff; m_max[k] = '0; m_valid[k] = 1'b0;
        end
        if (ev[k]) begin
          if (!cl && m_armed[k]) begin
            p = i - m_lt[k];
            m_last[k] = 16'(p);
            if (16'(p) < m_min[k]) m_min[k] = 16'(p);
            if (16'(p) > m_max[k]) m_max[k] = 16'(p);
            m_valid[k] = 1'b1;
          end
          m_armed[k] = 1'b1;
          m_lt[k] = i;
        end else if (cl) begin
          m_armed[k] = 1'b0;
        end
      end
      ph = (i == 0) ? 0 : (ph + 1) % FREQ;
      h3 = h2; h2 = h1; h1 = nin;
      step();
      for (int k = 0; k < NCH; k++) begin
        pk_last[k*W +: W] = m_last[k];
        pk_min[k*W +: W]  = m_min[k];
        pk_max[k*W +: W]  = m_max[k];
        pk_valid[k]       = m_valid[k];
      end
      chk($sformatf("rnd%0d_last", i), last_o, pk_last);
      chk($sformatf("rnd%0d_min", i), min_o, pk_min);
      chk($sformatf("rnd%0d_max", i), max_o, pk_max);
      chk($sformatf("rnd%0d_valid", i), valid_o, pk_valid);
      chk($sformatf("rnd%0d_timeout", i), timeout_o, 3'b000);
      chk($sformatf("rnd%0d_locked", i), locked_o, 1'b0);
      chk($sformatf("rnd%0d_holdover", i), holdover_o, 1'b0);
      chk($sformatf("rnd%0d_pps", i), pps_o, (ph < PPSW));
      chk($sformatf("rnd%0d_period_pps", i), period_pps_o, m_last[0]);
    end
    clr = 1'b0; force_pps = 1'b0;

    // saturation on channel 1, then clr coinciding with a channel 0 edge
    do_reset();
    pps_sel = 2'd0;
    repeat (65534) step();
    chk("sat_timeout_before", timeout_o[1], 1'b0);
    step();
    chk("sat_timeout_set", timeout_o[1], 1'b1);
    sync_in[1] = 1'b1; step(); sync_in[1] = 1'b0; step(); step();
    chk("sat_edge_clears_timeout", timeout_o[1], 1'b0);
    chk("sat_edge_not_recorded", valid_o[1], 1'b0);
    repeat (197) step();
    pulse(1, 50);
    chk("sat_rearmed_last", last_o[31:16], 16'd200);
    chk("sat_rearmed_valid", valid_o[1], 1'b1);
    pulse(0, 50);
    pulse(0, 50);
    chk("pre_clr_last0", last_o[15:0], 16'd50);
    sync_in[0] = 1'b1; step(); sync_in[0] = 1'b0; step();
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_min", min_o, 48'hffff_ffff_ffff);
    chk("clr_max", max_o, 48'h0);
    chk("clr_last", last_o, 48'h0);
    chk("clr_valid", valid_o, 3'b000);
    chk("clr_timeout", timeout_o, 3'b000);
    repeat (97) step();
    pulse(0, 10);
    chk("clr_armed_last0", last_o[15:0], 16'd100);
    chk("clr_armed_valid", valid_o, 3'b001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
